// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types, constants and sizing helpers for the binary conv datapath.
package bnn_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;
  localparam int DEF_IC = 8;
  localparam int DEF_OC = 4;
  localparam int DEF_K = 3;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_IMG = 30;
  function automatic int conv_out_size(int in, int k, int stride);
    return (in - k) / stride + 1;
  endfunction
  function automatic int acc_width(int ic, int k);
    return $clog2(ic * k * k + 1) + 1;
  endfunction
endpackage

// File: rtl/bnn_xnor_popcount.sv
// bnn_xnor_popcount: signed term 2*popcount(~(a^b)) - N over two N-bit vectors.
module bnn_xnor_popcount #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1) + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic signed [W-1:0] term
);
  logic [W-1:0] cnt;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + W'(a[i] ~^ b[i]);
  end
  assign term = signed'((cnt << 1) - W'(N));
endmodule

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: binary convolution, one kernel tap across all input channels per cycle,
// each accumulated sum thresholded per output channel into a binary output plane.
module bnn_conv_engine
  import bnn_pkg::*;
#(
  parameter int IC = DEF_IC,
  parameter int OC = DEF_OC,
  parameter int K = DEF_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int IMG_IN_SIZE = DEF_IMG,
  parameter int IMG_OUT_SIZE = conv_out_size(IMG_IN_SIZE, K, STRIDE),
  parameter int ACC_W = acc_width(IC, K)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_in [0:IC-1],
  input  logic [OC*IC*K*K-1:0] weights,
  input  logic [OC*ACC_W-1:0] thresholds,
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out [0:OC-1],
  output logic busy,
  output logic done
);
  localparam int OUTB = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int KW = $clog2(K + 1);
  localparam int PW = $clog2(IMG_OUT_SIZE + 1);
  localparam int OW = $clog2(OC + 1);
  localparam int TW = $clog2(IC + 1) + 1;
  if (IMG_IN_SIZE < K || K % 2 == 0) begin : g_bad_geometry
    $error("bnn_conv_engine: K must be odd and no larger than IMG_IN_SIZE");
  end
  state_t state, state_nxt;
  logic [KW-1:0] ky, kx;
  logic [PW-1:0] row, col;
  logic [OW-1:0] oc;
  logic signed [ACC_W-1:0] acc, thr;
  logic signed [TW-1:0] term;
  logic [IC-1:0] px, wv;
  logic last_tap, last_col, last_row, last_pix;
  int pix, widx, pos;
  always_comb begin
    pix = (int'(row) * STRIDE + int'(ky)) * IMG_IN_SIZE + int'(col) * STRIDE + int'(kx);
    widx = int'(oc) * IC * K * K + int'(ky) * K + int'(kx);
    pos = int'(row) * IMG_OUT_SIZE + int'(col);
    for (int i = 0; i < IC; i++) begin
      px[i] = 1'(img_in[i] >> pix);
      wv[i] = 1'(weights >> (widx + i * K * K));
    end
    thr = ACC_W'(thresholds >> (int'(oc) * ACC_W));
  end
  bnn_xnor_popcount #(.N(IC), .W(TW)) u_popcount (.a(px), .b(wv), .term(term));
  assign last_tap = ky == KW'(K - 1) && kx == KW'(K - 1);
  assign last_col = col == PW'(IMG_OUT_SIZE - 1);
  assign last_row = row == PW'(IMG_OUT_SIZE - 1);
  assign last_pix = last_col && last_row && oc == OW'(OC - 1);
  assign busy = state == ACCUM || state == WRITE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = start ? ACCUM : IDLE;
      ACCUM: state_nxt = last_tap ? WRITE : ACCUM;
      WRITE: state_nxt = last_pix ? DONE : ACCUM;
      default: state_nxt = IDLE;
    endcase
  end
  // kx/ky walk the taps row-major; ky overshoots to K after the last tap and WRITE clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      ky <= '0;
      kx <= '0;
      row <= '0;
      col <= '0;
      oc <= '0;
      for (int o = 0; o < OC; o++) img_out[o] <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      ky <= '0;
      kx <= '0;
      row <= '0;
      col <= '0;
      oc <= '0;
    end else if (state == ACCUM) begin
      acc <= acc + ACC_W'(term);
      kx <= kx == KW'(K - 1) ? '0 : kx + KW'(1);
      ky <= kx == KW'(K - 1) ? ky + KW'(1) : ky;
    end else if (state == WRITE) begin
      for (int o = 0; o < OC; o++)
        if (o == int'(oc))
          img_out[o] <= (img_out[o] & ~(OUTB'(1) << pos)) | (OUTB'(acc >= thr) << pos);
      acc <= '0;
      ky <= '0;
      kx <= '0;
      col <= last_col ? '0 : col + PW'(1);
      row <= last_col ? (last_row ? '0 : row + PW'(1)) : row;
      oc <= last_col && last_row ? oc + OW'(1) : oc;
    end
endmodule

// File: doc/bnn_conv_engine.md
Name: bnn_conv_engine

Overview:
- Multi-output-channel binary convolution engine with parametrised kernel size and stride.
- XNOR-popcounts a set of binary input planes against binary weights and compares each accumulated sum with a per-output-channel threshold (folded batch-norm/sign) to produce binary output planes.
- Sits between binary feature-map buffers in the BNN datapath.
- Processes one kernel tap across all input channels per cycle, controlled by a start/busy/done handshake.

Parameters:
IC, 8, input channel count
OC, 4, output channel count
K, 3, square kernel size (odd, >=1)
STRIDE, 1, convolution stride (>=1)
IMG_IN_SIZE, 30, input plane width and height (no padding)
IMG_OUT_SIZE, (IMG_IN_SIZE-K)/STRIDE+1, output plane width and height (derived; do not override)
ACC_W, $clog2(IC*K*K+1)+1, signed accumulator and threshold width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse to begin a convolution; honoured only in IDLE
img_in  input  [IMG_IN_SIZE*IMG_IN_SIZE-1:0] x [0:IC-1]  binary input planes, row-major, bit = row*IMG_IN_SIZE+col; held stable by the producer while busy
weights  input  OC*IC*K*K  binary weights, bit index ((oc*IC+ic)*K*K + ky*K + kx); held stable while busy
thresholds  input  OC*ACC_W  signed per-oc thresholds, slice oc at [oc*ACC_W +: ACC_W]; held stable while busy
img_out  output  [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] x [0:OC-1]  binary output planes, row-major
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when all output bits are written

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0; done=0; img_out all 0; acc=0; all counters (oc, row, col, tap) = 0.
- States:
  - IDLE: on start, go to ACCUM with counters 0, acc=0, busy=1. img_out is not cleared.
  - ACCUM: each cycle, acc += xnor_popcount term for tap (ky,kx) = (tap/K, tap%K). Term = 2*matches - IC, where matches counts ic with img_in[ic][(row*STRIDE+ky)*IMG_IN_SIZE + col*STRIDE+kx] == weights[(oc*IC+ic)*K*K + tap]. After tap K*K-1 is added, go to WRITE.
  - WRITE: img_out[oc][row*IMG_OUT_SIZE+col] <= (acc >= thresholds[oc]) as signed. Then acc=0, tap=0, and advance col, then row, then oc. If the last (oc,row,col) was just written, go to DONE; otherwise return to ACCUM.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency from accepted start to done: exactly OC*IMG_OUT_SIZE^2*(K*K+1)+1 cycles.
- start asserted in ACCUM, WRITE or DONE is ignored, with no queueing.
- A start in the IDLE cycle immediately following DONE is accepted. Back-to-back runs are legal.
- Arithmetic: acc is signed ACC_W bits, range [-IC*K*K, +IC*K*K], and never overflows by construction. With threshold 0, output = 1 iff acc >= 0, which is the sign convention of the existing core.
- img_out bits update only in WRITE. Untouched bits retain their previous values until overwritten in the same run.
- Reset mid-run aborts immediately: all state returns to reset values. No done pulse is issued.
- K=1, STRIDE>1 and IMG_OUT_SIZE=1 are all legal. Elaboration fails (static assertion) if IMG_IN_SIZE < K or K is even.

Decomposition:
- Package bnn_pkg holds:
  - state enum (IDLE, ACCUM, WRITE, DONE);
  - functions conv_out_size(in,k,stride) and acc_width(ic,k);
  - shared BNN constants.
- Sub-module bnn_xnor_popcount (parameter N): combinational. Takes two N-bit vectors and returns the signed term 2*popcount(~(a^b)) - N. It is instantiated once with N=IC and is reusable by future dense layers.

Test Plan:
- Ones: IC=1, OC=1, K=3, IMG_IN_SIZE=5, img_in all 0, weights all 0, threshold 0 -> all 9 img_out bits = 1; done exactly 1*9*10+1 = 91 cycles after start.
- Mismatch and threshold: same configuration, weights all 1 -> acc=-9 and img_out all 0. Rerun with threshold -9 -> all 1. Rerun with threshold -8 -> all 0.
- Stride and multi-oc: IC=2, OC=2, K=3, STRIDE=2, IMG_IN_SIZE=7 (OUT=3), checkerboard image, oc0 weights = checkerboard, oc1 weights = inverted checkerboard, thresholds 0.
  - Center-aligned windows give oc0 sum +18 -> 1 and oc1 sum -18 -> 0.
  - Full plane compared against a reference model.
- Handshake: start pulsed again mid-run -> ignored and done timing unchanged. start in the cycle after done -> second run completes with correct results. busy and done are never high together.
- Reset mid-run: assert rst during ACCUM of pixel (0,1) -> img_out=0, busy=0, done stays 0. A fresh start afterwards completes normally.
- Random regression: IC=8, OC=4, K=3, IMG_IN_SIZE=30, random image, weights and thresholds across 20 runs -> bit-exact match to the software model.
